// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: each note event scans the voices serially,
// then retriggers a matching voice, takes a free one, or steals the oldest.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int STEAL_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic [7:0]              key,
    input  logic [7:0]              velocity,
    input  logic                    all_off,
    input  logic                    sample_tick,
    output logic [8*NUM_VOICES-1:0] voice_key,
    output logic [8*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic                    dropped,
    output logic [4:0]              active_count
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic             init_done;
    logic [IDX_W-1:0] scan_idx;
    logic [7:0]       key_lat;
    logic [7:0]       vel_lat;
    logic [AGE_W-1:0] age [NUM_VOICES];

    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx;
    logic [AGE_W-1:0] old_age;

    logic [7:0]       cur_key;
    logic             cur_gate;
    logic [AGE_W-1:0] cur_age;
    logic             tgt_found;
    logic [IDX_W-1:0] tgt_idx;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + AGE_W'(1);
    endfunction

    function automatic logic [4:0] popcount(input logic [NUM_VOICES-1:0] g);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOICES; i++) c = c + 5'(g[i]);
        return c;
    endfunction

    assign note_ready = (state == IDLE) && init_done;

    always_comb begin
        cur_key  = voice_key[8*int'(scan_idx) +: 8];
        cur_gate = voice_gate[scan_idx];
        cur_age  = age[scan_idx];
    end

    // Target priority: retrigger a held key, then a free voice, then steal.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = '0;
        if (match_found) begin
            tgt_found = 1'b1;
            tgt_idx   = match_idx;
        end else if (free_found) begin
            tgt_found = 1'b1;
            tgt_idx   = free_idx;
        end else if (STEAL_MODE != 0 && old_found) begin
            tgt_found = 1'b1;
            tgt_idx   = old_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            init_done    <= 1'b0;
            scan_idx     <= '0;
            key_lat      <= '0;
            vel_lat      <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            old_found    <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            old_idx      <= '0;
            old_age      <= '0;
            voice_key    <= '0;
            voice_vel    <= '0;
            voice_gate   <= '0;
            voice_trig   <= '0;
            dropped      <= 1'b0;
            active_count <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
        end else begin
            init_done    <= 1'b1;
            dropped      <= 1'b0;
            active_count <= popcount(voice_gate);
            if (sample_tick) voice_trig <= '0;

            case (state)
                IDLE: begin
                    if (note_valid && init_done) begin
                        key_lat     <= key;
                        vel_lat     <= velocity;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_gate && cur_key == key_lat && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!cur_gate && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strict compare keeps the lowest index on equal ages.
                    if (cur_gate && (!old_found || cur_age > old_age)) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= cur_age;
                    end
                    if (scan_idx == LAST_IDX) state <= COMMIT;
                    else scan_idx <= scan_idx + IDX_W'(1);
                end
                COMMIT: begin
                    state <= IDLE;
                    if (vel_lat != 8'd0) begin
                        if (tgt_found) begin
                            voice_key[8*int'(tgt_idx) +: 8] <= key_lat;
                            voice_vel[8*int'(tgt_idx) +: 8] <= vel_lat;
                            voice_gate[tgt_idx] <= 1'b1;
                            voice_trig[tgt_idx] <= 1'b1;
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == tgt_idx) age[i] <= '0;
                                else if (voice_gate[i]) age[i] <= age_inc(age[i]);
                            end
                        end else begin
                            dropped <= 1'b1;
                        end
                    end else if (match_found) begin
                        voice_gate[match_idx] <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Panic overrides everything above, including an in-flight event.
            if (all_off) begin
                voice_gate <= '0;
                voice_trig <= '0;
                dropped    <= 1'b0;
                for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
                if (state != IDLE) state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: stealing and dropping instances driven in lockstep.
module tb_midi_voice_alloc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        note_valid = 1'b0;
    logic [7:0]  key = '0;
    logic [7:0]  velocity = '0;
    logic        all_off = 1'b0;
    logic        sample_tick = 1'b0;

    logic        ready1, ready0;
    logic [31:0] vkey1, vkey0, vvel1, vvel0;
    logic [3:0]  gate1, gate0, trig1, trig0;
    logic        drop1, drop0;
    logic [4:0]  cnt1, cnt0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    midi_voice_alloc #(.NUM_VOICES(4), .AGE_W(4), .STEAL_MODE(1)) dut (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(ready1),
        .key(key), .velocity(velocity), .all_off(all_off), .sample_tick(sample_tick),
        .voice_key(vkey1), .voice_vel(vvel1), .voice_gate(gate1), .voice_trig(trig1),
        .dropped(drop1), .active_count(cnt1)
    );

    midi_voice_alloc #(.NUM_VOICES(4), .AGE_W(4), .STEAL_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .note_valid(note_valid), .note_ready(ready0),
        .key(key), .velocity(velocity), .all_off(all_off), .sample_tick(sample_tick),
        .voice_key(vkey0), .voice_vel(vvel0), .voice_gate(gate0), .voice_trig(trig0),
        .dropped(drop0), .active_count(cnt0)
    );

    typedef struct {
        logic [7:0]  key;
        logic [7:0]  vel;
        logic [3:0]  gate1;
        logic [31:0] keys1;
        logic [3:0]  trig1;
        logic [3:0]  gate0;
        logic [31:0] keys0;
        logic [3:0]  trig0;
        logic        drop0;
        logic [7:0]  vel_v0;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] k, input logic [7:0] v, input logic tick_commit,
                        input logic [3:0] pg1, input logic [3:0] pg0);
        int n;
        n = 0;
        while (!(ready1 && ready0) && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_note", {ready1, ready0}, 2'b11);
        key = k;
        velocity = v;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        chk("ready_low_in_scan", {ready1, ready0}, 2'b00);
        repeat (4) tick();
        chk("gate_before_commit", {gate1, gate0}, {pg1, pg0});
        sample_tick = tick_commit;
        tick();
        sample_tick = 1'b0;
    endtask

    task automatic run_vec(input int i, input logic [3:0] pg1, input logic [3:0] pg0);
        vec_t v;
        v = vecs[i];
        send(v.key, v.vel, 1'b0, pg1, pg0);
        chk($sformatf("v%0d_gate", i), {gate1, gate0}, {v.gate1, v.gate0});
        chk($sformatf("v%0d_keys", i), {vkey1, vkey0}, {v.keys1, v.keys0});
        chk($sformatf("v%0d_trig", i), {trig1, trig0}, {v.trig1, v.trig0});
        chk($sformatf("v%0d_vel0", i), {vvel1[7:0], vvel0[7:0]}, {v.vel_v0, v.vel_v0});
        chk($sformatf("v%0d_drop", i), {drop1, drop0}, {1'b0, v.drop0});
        chk($sformatf("v%0d_ready", i), {ready1, ready0}, 2'b11);
        tick();
        chk($sformatf("v%0d_count", i), {cnt1, cnt0},
            {5'($countones(v.gate1)), 5'($countones(v.gate0))});
        chk($sformatf("v%0d_drop_clr", i), {drop1, drop0}, 2'b00);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        chk($sformatf("v%0d_trig_clr", i), {trig1, trig0}, 8'h00);
    endtask

    initial begin
        logic [3:0] pg1, pg0;
        logic       seen_drop;

        vecs[0] = '{8'd60, 8'd100, 4'b0001, 32'h0000003C, 4'b0001, 4'b0001, 32'h0000003C, 4'b0001, 1'b0, 8'd100};
        vecs[1] = '{8'd62, 8'd100, 4'b0011, 32'h00003E3C, 4'b0010, 4'b0011, 32'h00003E3C, 4'b0010, 1'b0, 8'd100};
        vecs[2] = '{8'd64, 8'd100, 4'b0111, 32'h00403E3C, 4'b0100, 4'b0111, 32'h00403E3C, 4'b0100, 1'b0, 8'd100};
        vecs[3] = '{8'd65, 8'd100, 4'b1111, 32'h41403E3C, 4'b1000, 4'b1111, 32'h41403E3C, 4'b1000, 1'b0, 8'd100};
        vecs[4] = '{8'd67, 8'd100, 4'b1111, 32'h41403E43, 4'b0001, 4'b1111, 32'h41403E3C, 4'b0000, 1'b1, 8'd100};
        vecs[5] = '{8'd67, 8'd0,   4'b1110, 32'h41403E43, 4'b0000, 4'b1111, 32'h41403E3C, 4'b0000, 1'b0, 8'd100};
        vecs[6] = '{8'd62, 8'd100, 4'b0001, 32'h41403E3E, 4'b0001, 4'b0001, 32'h41403E3E, 4'b0001, 1'b0, 8'd100};
        vecs[7] = '{8'd62, 8'd80,  4'b0001, 32'h41403E3E, 4'b0001, 4'b0001, 32'h41403E3E, 4'b0001, 1'b0, 8'd80};
        vecs[8] = '{8'd62, 8'd0,   4'b0000, 32'h41403E3E, 4'b0000, 4'b0000, 32'h41403E3E, 4'b0000, 1'b0, 8'd80};
        vecs[9] = '{8'd70, 8'd0,   4'b0000, 32'h41403E3E, 4'b0000, 4'b0000, 32'h41403E3E, 4'b0000, 1'b0, 8'd80};

        // Reset state
        #12;
        chk("rst_ready", {ready1, ready0}, 2'b00);
        chk("rst_gate_trig", {gate1, trig1, gate0, trig0}, 16'h0000);
        chk("rst_keys", {vkey1, vkey0}, 64'h0);
        chk("rst_count_drop", {cnt1, drop1, cnt0, drop0}, 12'h000);
        rst = 1'b1;
        #1 chk("ready_before_first_edge", {ready1, ready0}, 2'b00);
        tick();
        chk("ready_first_edge", {ready1, ready0}, 2'b11);

        // Fill, steal/drop, note-off
        pg1 = 4'b0000;
        pg0 = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            run_vec(i, pg1, pg0);
            pg1 = vecs[i].gate1;
            pg0 = vecs[i].gate0;
        end

        // Panic in the middle of a scan
        key = 8'd72;
        velocity = 8'd100;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        tick();
        tick();
        all_off = 1'b1;
        tick();
        all_off = 1'b0;
        chk("alloff_gate", {gate1, gate0}, 8'h00);
        chk("alloff_trig", {trig1, trig0}, 8'h00);
        chk("alloff_idle", {ready1, ready0}, 2'b11);
        chk("alloff_drop", {drop1, drop0}, 2'b00);
        seen_drop = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen_drop = seen_drop | drop1 | drop0;
        end
        chk("alloff_no_late_drop", seen_drop, 1'b0);
        chk("alloff_count", {cnt1, cnt0}, 10'h000);
        chk("alloff_keys_kept", {vkey1, vkey0}, {32'h41403E43, 32'h41403E3C});

        // Retrigger and release sequence
        pg1 = 4'b0000;
        pg0 = 4'b0000;
        for (int i = 6; i < 10; i++) begin
            run_vec(i, pg1, pg0);
            pg1 = vecs[i].gate1;
            pg0 = vecs[i].gate0;
        end

        // sample_tick coinciding with the commit edge
        send(8'd50, 8'd100, 1'b1, 4'b0000, 4'b0000);
        chk("coinc_trig_survives", {trig1, trig0}, 8'h11);
        chk("coinc_key", {vkey1[7:0], vkey0[7:0]}, 16'h3232);
        tick();
        chk("coinc_trig_hold", {trig1, trig0}, 8'h11);
        sample_tick = 1'b1;
        tick();
        sample_tick = 1'b0;
        chk("coinc_trig_clr", {trig1, trig0}, 8'h00);

        // Reset mid-scan
        key = 8'd52;
        velocity = 8'd90;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_gate", {gate1, gate0}, 8'h00);
        chk("rstmid_keys_vels", {vkey1, vvel1}, 64'h0);
        chk("rstmid_ready_count", {ready1, cnt1, ready0, cnt0}, 12'h000);
        tick();
        chk("rstmid_held", {gate1, trig1, drop1}, 9'h000);
        rst = 1'b1;
        #1 chk("rstmid_ready_pre_edge", {ready1, ready0}, 2'b00);
        tick();
        chk("rstmid_ready_after", {ready1, ready0}, 2'b11);
        chk("rstmid_no_partial", {gate1, gate0, vkey1[15:0]}, 24'h000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, voice count (legal 2..16).
REQ-002 SHALL have parameter AGE_W, default 4, width of the per-voice age counter.
REQ-003 SHALL have parameter STEAL_MODE, default 1; 1 = steal the oldest voice when full, 0 = drop the new note.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-006 SHALL have port note_valid  input  1  a key/velocity pair is presented.
REQ-007 SHALL have port note_ready  output  1  block accepts a note this cycle.
REQ-008 SHALL have port key  input  8  MIDI key number.
REQ-009 SHALL have port velocity  input  8  MIDI velocity; 0 = note-off.
REQ-010 SHALL have port all_off  input  1  synchronous panic: release all voices.
REQ-011 SHALL have port sample_tick  input  1  one-cycle pulse per audio sample.
REQ-012 SHALL have port voice_key  output  8*NUM_VOICES  key of voice i at bits [8i+7:8i].
REQ-013 SHALL have port voice_vel  output  8*NUM_VOICES  velocity of voice i.
REQ-014 SHALL have port voice_gate  output  NUM_VOICES  voice i sounding.
REQ-015 SHALL have port voice_trig  output  NUM_VOICES  voice i restart request.
REQ-016 SHALL have port dropped  output  1  one-cycle pulse: note-on discarded (STEAL_MODE=0, all voices gated).
REQ-017 SHALL have port active_count  output  5  number of set voice_gate bits.

Function
REQ-018 SHALL use an FSM with states IDLE, SCAN and COMMIT.
REQ-019 IDLE: note_ready=1; on note_valid&note_ready, SHALL latch key/velocity and enter SCAN with scan index 0.
REQ-020 SCAN: note_ready=0; SHALL examine one voice per cycle, index 0..NUM_VOICES-1, then enter COMMIT; handshake-to-update latency is therefore NUM_VOICES+2 cycles.
REQ-021 During SCAN, SHALL record: the first voice with gate=1 and matching key (match); the lowest-index voice with gate=0 (free); and the gated voice with the largest age, ties going to the lowest index (oldest).
REQ-022 COMMIT note-on (velocity!=0): the target SHALL be match if found, else free if found, else oldest when STEAL_MODE=1; if none, SHALL pulse dropped and leave all voices unchanged.
REQ-023 COMMIT note-on with a target: SHALL write voice_key/voice_vel, set gate and trig, clear the target's age, and increment (saturating at 2^AGE_W-1) the age of every other gated voice.
REQ-024 COMMIT note-off (velocity==0): SHALL clear the gate of the match voice only; key/vel/age SHALL be kept; if there is no match, no state SHALL change and dropped SHALL stay 0.
REQ-025 COMMIT SHALL last one cycle and then return to IDLE; note_ready SHALL rise the cycle after COMMIT.
REQ-026 voice_trig[i] SHALL stay set from COMMIT until the cycle after the next sample_tick; if sample_tick coincides with COMMIT, trig SHALL survive until the following sample_tick.
REQ-027 all_off SHALL clear all gates, trigs and ages in the same edge; in SCAN or COMMIT it SHALL also abort the pending event and return to IDLE without a dropped pulse.
REQ-028 active_count SHALL be registered and equal popcount(voice_gate) one cycle after any gate change.
REQ-029 Gates SHALL change only in COMMIT or on all_off; voice_key/voice_vel SHALL change only in COMMIT.

Reset
REQ-030 While rst=0: FSM=IDLE; note_ready=0; voice_gate, voice_trig, ages, voice_key, voice_vel, active_count and dropped all 0.
REQ-031 note_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-032 Reset asserted mid-SCAN SHALL discard the event immediately; no partial voice update SHALL be visible.

Verification
REQ-033 Default params: note-on key=60 vel=100 -> after 6 cycles, voice 0 has key 60, gate=1, trig=1, and active_count=1 one cycle later; trig clears the cycle after the next sample_tick.
REQ-034 Keys 60,62,64,65 on, then 67 on, STEAL_MODE=1 -> voice 0 (age 3) takes key 67; other gates stay set; active_count=4.
REQ-035 Same sequence with STEAL_MODE=0 -> dropped pulses once; voice_key is unchanged.
REQ-036 Key 62 on, 62 on again with vel=80 -> the same voice retriggers, vel=80, active_count=1; then 62 vel=0 -> gate clears; then 70 vel=0 -> no change.
REQ-037 all_off asserted during SCAN of a note-on -> all gates 0, FSM in IDLE next cycle, dropped=0.
REQ-038 rst pulsed low mid-SCAN -> all outputs 0 asynchronously; note_ready=1 on the first edge after release.
